neuron_writeback: RTL

- Consumer end of the activation-stage result interface: accepts the 1-cycle write pulse plus 16-bit value and 16-bit destination, and commits the value into neuron value memory.
- A small FIFO absorbs results, because the producer has no backpressure.
- A req/ack state machine drives the memory write port.
- Reports per-write completion, a running write count and sticky error flags to the network sequencer.

---
 rtl/neuron_writeback_if.sv | 36 +++
 rtl/neuron_writeback.sv | 132 +++++++++++++
 2 files changed

// File: rtl/neuron_writeback_if.sv
// ============================================================================
// Module   : neuron_writeback_if
// Brief    : Result-in / memory-write-out / status bundle for neuron_writeback.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface neuron_writeback_if #(
  parameter int ADDR_W = 8
);
  logic [15:0]       in_val;
  logic [15:0]       in_dest;
  logic              in_we;
  logic              clr_err;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_ack;
  logic              done;
  logic [15:0]       wr_count;
  logic              busy;
  logic              overflow;
  logic              range_err;

  modport slave (
    input  in_val, in_dest, in_we, clr_err, mem_ack,
    output mem_req, mem_addr, mem_wdata, done, wr_count, busy, overflow, range_err
  );

  modport master (
    output in_val, in_dest, in_we, clr_err, mem_ack,
    input  mem_req, mem_addr, mem_wdata, done, wr_count, busy, overflow, range_err
  );
endinterface

`default_nettype wire

// File: rtl/neuron_writeback.sv
// ============================================================================
// Module   : neuron_writeback
// Brief    : Buffers activation results in a small FIFO and commits them to
//            neuron value memory over a req/ack write port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module neuron_writeback #(
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = 8,
  parameter int NUM_NEURONS = 256
) (
  input  wire logic          clk,
  input  wire logic          rst,
  neuron_writeback_if.slave  bus_io
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       wr_count_q, wr_count_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              rerr_q, rerr_d;

  logic              empty, full, push, pop, head_bad, rerr_set, ovf_set;
  logic [15:0]       head_dest, head_val;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign head_dest = fifo_q[rd_ptr_q][31:16];
  assign head_val  = fifo_q[rd_ptr_q][15:0];
  // Full 16-bit destination is range checked; only the low ADDR_W bits address memory.
  assign head_bad  = ({16'h0000, head_dest} >= 32'(NUM_NEURONS));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_count_d = wr_count_q;
    done_d     = 1'b0;
    pop        = 1'b0;
    rerr_set   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (head_bad) begin
            pop      = 1'b1;
            rerr_set = 1'b1;
          end else begin
            addr_d  = head_dest[ADDR_W-1:0];
            wdata_d = head_val;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (bus_io.mem_ack) begin
          pop        = 1'b1;
          done_d     = 1'b1;
          wr_count_d = wr_count_q + 16'd1;
          state_d    = IDLE;
        end
      end
    endcase
    // A full FIFO still accepts when the head leaves on the same edge.
    push    = bus_io.in_we && (!full || pop);
    ovf_set = bus_io.in_we && full && !pop;
    ovf_d   = ovf_set  | (ovf_q  & ~bus_io.clr_err);
    rerr_d  = rerr_set | (rerr_q & ~bus_io.clr_err);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {bus_io.in_dest, bus_io.in_val};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_count_q <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_count_q <= wr_count_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      rerr_q     <= rerr_d;
      count_q    <= count_q + CNT_W'(push) - CNT_W'(pop);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  assign bus_io.mem_req   = (state_q == REQ);
  assign bus_io.mem_addr  = addr_q;
  assign bus_io.mem_wdata = wdata_q;
  assign bus_io.done      = done_q;
  assign bus_io.wr_count  = wr_count_q;
  assign bus_io.busy      = (count_q != '0) | (state_q != IDLE);
  assign bus_io.overflow  = ovf_q;
  assign bus_io.range_err = rerr_q;

endmodule

`default_nettype wire
